// File: rtl/sqrt_unit.sv
// Integer square-root engine: restoring, one root bit per clock, with valid/ready on both sides.
// Optional macro SQRT_ROUND_EN rounds the reported root to nearest (saturating).
module sqrt_unit #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   radicand,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem,
    output logic               busy
);
    localparam int RW = WIDTH / 2;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    generate
        if ((WIDTH % 2 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("sqrt_unit: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [RW-1:0]   root_p_q, root_p_d;
    logic [RW+1:0]   rem_p_q, rem_p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   root_q, root_d;
    logic [RW:0]     rem_q, rem_d;
    logic            out_valid_q, out_valid_d;

    logic [RW+1:0]   shifted_in;
    logic [RW+1:0]   trial;
    logic            take;
    logic [RW+1:0]   rem_step;
    logic [RW-1:0]   root_step;
    logic [RW-1:0]   root_final;

    // The partial remainder never exceeds RW bits before an iteration, so its top bits are always zero.
    logic unused_rem_hi;
    assign unused_rem_hi = ^rem_p_q[RW+1:RW];

    always_comb begin
        shifted_in = {rem_p_q[RW-1:0], shift_q[WIDTH-1 -: 2]};
        trial      = shifted_in - {root_p_q, 2'b01};
        take       = ~trial[RW+1];
        rem_step   = take ? trial : shifted_in;
        root_step  = {root_p_q[RW-2:0], take};
    end

`ifdef SQRT_ROUND_EN
    logic round_up;

    always_comb begin
        round_up   = (rem_step[RW:0] > {1'b0, root_step}) && (root_step != {RW{1'b1}});
        root_final = round_up ? (root_step + RW'(1)) : root_step;
    end
`else
    always_comb begin
        root_final = root_step;
    end
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        root_p_d    = root_p_q;
        rem_p_d     = rem_p_q;
        cnt_d       = cnt_q;
        root_d      = root_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d  = radicand;
                    root_p_d = '0;
                    rem_p_d  = '0;
                    cnt_d    = CW'(RW - 1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                shift_d  = shift_q << 2;
                root_p_d = root_step;
                rem_p_d  = rem_step;
                if (cnt_q == '0) begin
                    root_d      = root_final;
                    rem_d       = rem_step[RW:0];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            root_p_q    <= '0;
            rem_p_q     <= '0;
            cnt_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            root_p_q    <= root_p_d;
            rem_p_q     <= rem_p_d;
            cnt_q       <= cnt_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign root      = root_q;
    assign rem       = rem_q;

endmodule

// File: tb/tb_sqrt_unit.sv
// Self-checking bench for sqrt_unit (WIDTH=16): vector table, handshake corner cases, random sweep.
module tb_sqrt_unit;
    localparam int WIDTH   = 16;
    localparam int RW      = WIDTH / 2;
    localparam int LATENCY = RW;

    logic             clk;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] radicand;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    root;
    logic [RW:0]      rem;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    sqrt_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .radicand  (radicand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root      (root),
        .rem       (rem),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rad;
        int rootFloor;
        int rootRound;
        int remExp;
    } vector_t;

    // Reference: floor root by search, remainder from the truncated root, optional nearest rounding.
    task automatic refSqrt(input int x, output int r, output int m);
        int t;
        t = 0;
        while ((t + 1) * (t + 1) <= x) t++;
        m = x - t * t;
`ifdef SQRT_ROUND_EN
        if ((m > t) && (t < (1 << RW) - 1)) r = t + 1;
        else r = t;
`else
        r = t;
`endif
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic acceptOperand(input int x);
        int waitCycles;
        @(negedge clk);
        in_valid = 1'b1;
        radicand = x[WIDTH-1:0];
        waitCycles = 0;
        while (!in_ready && waitCycles < 40) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("accept_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        bit done;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) done = 1'b1;
        end
        checkOutput("result_arrived", int'(done), 1);
    endtask

    task automatic applyStimulus(input int x, output int lat);
        acceptOperand(x);
        waitResult(lat);
    endtask

    task automatic takeResult();
        @(posedge clk);
        @(negedge clk);
        checkOutput("taken_out_valid", int'(out_valid), 0);
        checkOutput("taken_in_ready", int'(in_ready), 1);
    endtask

    vector_t vecs[$];

    initial begin
        int lat;
        int er;
        int em;
        int x;

        vecs.push_back('{144,   12,  12,  0});
        vecs.push_back('{0,     0,   0,   0});
        vecs.push_back('{65535, 255, 255, 510});
        vecs.push_back('{157,   12,  13,  13});
        vecs.push_back('{150,   12,  12,  6});
        vecs.push_back('{1000,  31,  32,  39});
        vecs.push_back('{49,    7,   7,   0});
        vecs.push_back('{1,     1,   1,   0});
        vecs.push_back('{2,     1,   1,   1});
        vecs.push_back('{3,     1,   2,   2});
        vecs.push_back('{65025, 255, 255, 0});
        vecs.push_back('{65024, 254, 255, 508});

        clr       = 1'b1;
        in_valid  = 1'b0;
        radicand  = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_root", int'(root), 0);
        checkOutput("reset_rem", int'(rem), 0);
        clr = 1'b0;

        $display("[TB] vector table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rad, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, LATENCY);
            checkOutput($sformatf("vec%0d_busy", i), int'(busy), 1);
`ifdef SQRT_ROUND_EN
            checkOutput($sformatf("vec%0d_root", i), int'(root), vecs[i].rootRound);
`else
            checkOutput($sformatf("vec%0d_root", i), int'(root), vecs[i].rootFloor);
`endif
            checkOutput($sformatf("vec%0d_rem", i), int'(rem), vecs[i].remExp);
            takeResult();
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        refSqrt(1000, er, em);
        applyStimulus(1000, lat);
        checkOutput("bp_latency", lat, LATENCY);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", int'(out_valid), 1);
            checkOutput("bp_in_ready", int'(in_ready), 0);
            checkOutput("bp_root", int'(root), er);
            checkOutput("bp_rem", int'(rem), em);
            if (i == 2) begin
                in_valid = 1'b1;
                radicand = 16'd4;
            end
            if (i == 3) in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_taken_out_valid", int'(out_valid), 0);
        checkOutput("bp_taken_in_ready", int'(in_ready), 1);
        checkOutput("bp_root_held", int'(root), er);
        checkOutput("bp_rem_held", int'(rem), em);

        $display("[TB] clear mid-calculation");
        acceptOperand(5000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        #1;
        checkOutput("clr_in_ready", int'(in_ready), 1);
        checkOutput("clr_out_valid", int'(out_valid), 0);
        checkOutput("clr_busy", int'(busy), 0);
        checkOutput("clr_root", int'(root), 0);
        checkOutput("clr_rem", int'(rem), 0);
        @(negedge clk);
        clr = 1'b0;
        applyStimulus(49, lat);
        checkOutput("post_clr_latency", lat, LATENCY);
        checkOutput("post_clr_root", int'(root), 7);
        checkOutput("post_clr_rem", int'(rem), 0);
        takeResult();

        $display("[TB] random sweep");
        for (int n = 0; n < 2000; n++) begin
            x = int'($urandom_range(65535, 0));
            refSqrt(x, er, em);
            applyStimulus(x, lat);
            checkOutput("rnd_latency", lat, LATENCY);
            checkOutput($sformatf("rnd_root(%0d)", x), int'(root), er);
            checkOutput($sformatf("rnd_rem(%0d)", x), int'(rem), em);
            @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
